signed_shift_add_multiplier: RTL and testbench

- Sequential signed multiplier: WIDTH x WIDTH two's-complement operands produce a 2*WIDTH two's-complement product.
- It is the inverse companion of the signed divider in the calculator datapath. Its product width matches the divider's dividend width.
- Uses a sign-magnitude shift-add core with one iteration per clock.
- Uses the same START/DONE handshake as the divider, so the calculator controller drives both blocks identically.

---
 rtl/signed_shift_add_multiplier_if.sv | 22 ++
 rtl/signed_shift_add_multiplier.sv | 106 ++++++++++
 tb/tb_signed_shift_add_multiplier.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/signed_shift_add_multiplier_if.sv
// START/DONE handshake and operand/result bus shared by the calculator's multiplier and divider.
// The controller drives the master side; the arithmetic block is the slave.
interface signed_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 START;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic [2*WIDTH-1:0]   Product;
  logic                 DONE;
  logic                 BUSY;

  modport master (
    output START, Multiplicand, Multiplier,
    input  Product, DONE, BUSY
  );

  modport slave (
    input  START, Multiplicand, Multiplier,
    output Product, DONE, BUSY
  );
endinterface

// File: rtl/signed_shift_add_multiplier.sv
// Signed WIDTHxWIDTH multiplier: sign-magnitude shift-add core, one partial product per clock.
// Latency: START edge to DONE = WIDTH+1 edges; START is ignored while an operation is in flight.
module signed_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                          CLOCK,
  input  logic                          RESET_N,
  signed_shift_add_multiplier_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, SIGN, FINISH} state_t;

  state_t               state_q, state_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod_mag;

  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign prod_mag = {acc_q, q_q};

  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    mag_a_d   = mag_a_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    sum       = '0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          neg_d   = bus.Multiplicand[WIDTH-1] ^ bus.Multiplier[WIDTH-1];
          mag_a_d = magnitude(bus.Multiplicand);
          q_d     = magnitude(bus.Multiplier);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        // The carry lives only in sum[WIDTH]; after the right shift the top bit is always zero.
        sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
        acc_d   = sum[WIDTH:1];
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        product_d = neg_q ? -prod_mag : prod_mag;
        state_d   = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == FINISH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      neg_q     <= 1'b0;
      mag_a_q   <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      neg_q     <= neg_d;
      mag_a_q   <= mag_a_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.Product = product_q;
  assign bus.DONE    = done_q;
  assign bus.BUSY    = busy_q;
endmodule

// File: tb/tb_signed_shift_add_multiplier.sv
// Bench for signed_shift_add_multiplier: fixed vector table, handshake corner sequences,
// and randomized operands checked against plain integer multiplication.
module tb_signed_shift_add_multiplier;
  localparam int W = 8;

  logic CLOCK;
  logic RESET_N;
  int   checks;
  int   failures;

  signed_shift_add_multiplier_if #(.WIDTH(W)) bus ();

  signed_shift_add_multiplier #(.WIDTH(W)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia;
    int ib;
    int pr;
    ia = int'($signed(a));
    ib = int'($signed(b));
    pr = ia * ib;
    return pr[2*W-1:0];
  endfunction

  // One-cycle START pulse; lat counts negedges from START assertion until DONE is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] p, output int lat);
    @(negedge CLOCK);
    bus.Multiplicand = a;
    bus.Multiplier   = b;
    bus.START        = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
    lat = 1;
    check("busy_after_start", 32'(bus.BUSY), 32'd1);
    while (!bus.DONE && lat < 40) begin
      @(negedge CLOCK);
      lat++;
    end
    if (!bus.DONE) check("done_timeout", 32'(lat), 32'd10);
    p = bus.Product;
    check("busy_with_done", 32'(bus.BUSY), 32'd1);
    @(negedge CLOCK);
    check("done_one_cycle", 32'(bus.DONE), 32'd0);
    check("busy_cleared", 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    logic [2*W-1:0] p;
    int             lat;
    int             ndone;
    int             last_done;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    checks   = 0;
    failures = 0;
    vecs[0] = '{8'h07, 8'hFD, 16'hFFEB};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[3] = '{8'h80, 8'h7F, 16'hC080};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{8'h00, 8'h80, 16'h0000};
    vecs[6] = '{8'hFB, 8'h00, 16'h0000};

    RESET_N          = 1'b0;
    bus.START        = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    repeat (3) @(negedge CLOCK);
    check("reset_product", 32'(bus.Product), 32'd0);
    check("reset_done", 32'(bus.DONE), 32'd0);
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, p, lat);
      check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].p));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
    end

    // Operand changes and a second START while busy must be ignored.
    @(negedge CLOCK);
    bus.Multiplicand = 8'd12;
    bus.Multiplier   = 8'd10;
    bus.START        = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
    repeat (3) @(negedge CLOCK);
    bus.Multiplicand = 8'h99;
    bus.Multiplier   = 8'h55;
    bus.START        = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
    ndone = 0;
    p     = '0;
    for (int c = 0; c < 25; c++) begin
      if (bus.DONE) begin
        ndone++;
        p = bus.Product;
      end
      @(negedge CLOCK);
    end
    check("busy_ignore_product", 32'(p), 32'h0078);
    check("busy_ignore_done_count", 32'(ndone), 32'd1);

    // START held high: back-to-back operations every IDLE+ITER+SIGN+FINISH period.
    bus.Multiplicand = 8'd3;
    bus.Multiplier   = 8'd4;
    bus.START        = 1'b1;
    ndone     = 0;
    last_done = -1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge CLOCK);
      if (c == 30) bus.START = 1'b0;
      if (bus.DONE) begin
        ndone++;
        check("b2b_product", 32'(bus.Product), 32'h000C);
        if (last_done >= 0) check("b2b_spacing", 32'(c - last_done), 32'd11);
        else check("b2b_first_latency", 32'(c), 32'd10);
        last_done = c;
      end
    end
    check("b2b_done_count", 32'(ndone), 32'd3);

    // Asynchronous reset in the middle of ITER aborts the operation.
    @(negedge CLOCK);
    bus.Multiplicand = 8'd5;
    bus.Multiplier   = 8'hF9;
    bus.START        = 1'b1;
    @(negedge CLOCK);
    bus.START = 1'b0;
    repeat (4) @(negedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    check("async_rst_product", 32'(bus.Product), 32'd0);
    check("async_rst_done", 32'(bus.DONE), 32'd0);
    check("async_rst_busy", 32'(bus.BUSY), 32'd0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLOCK);
      if (bus.DONE) ndone++;
    end
    check("aborted_no_done", 32'(ndone), 32'd0);
    run_op(8'hFE, 8'd64, p, lat);
    check("after_rst_product", 32'(p), 32'hFF80);
    check("after_rst_latency", 32'(lat), 32'd10);

    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n == 0) ra = 8'h80;
      if (n == 1) rb = 8'h80;
      run_op(ra, rb, p, lat);
      check($sformatf("rand_%0h_x_%0h", ra, rb), 32'(p), 32'(model(ra, rb)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
